ahb_lite_master_arbiter: RTL and testbench

- Shares one AHB-Lite bus (toward decoder/slaves) between two requesting masters, M0 and M1.
- Registered grant, re-evaluated only at safe boundaries: no mid-burst, no mid-lock, no pending address phase.
- Muxes address/control and HWDATA; routes HREADY/HRESP per master; broadcasts HRDATA.
- Sits between the DMA/CPU masters and the address decoder, upstream of the slave devices.

---
 rtl/ahb_lite_pkg.sv | 53 +++++
 rtl/ahb_lite_burst_tracker.sv | 52 +++++
 rtl/ahb_lite_master_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ahb_lite_master_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and helpers.
//   htrans_e  : IDLE / BUSY / NONSEQ / SEQ
//   hburst_e  : SINGLE .. INCR16
//   hsize_e   : BYTE .. 32WORD
//   hresp_e   : OKAY / ERROR
//   burst_beats() : beats remaining after the NONSEQ beat of a fixed-length burst
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE   = 3'd0,
      HSIZE_HALF   = 3'd1,
      HSIZE_WORD   = 3'd2,
      HSIZE_DWORD  = 3'd3,
      HSIZE_4WORD  = 3'd4,
      HSIZE_8WORD  = 3'd5,
      HSIZE_16WORD = 3'd6,
      HSIZE_32WORD = 3'd7
   } hsize_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   // Undefined-length INCR and SINGLE give 0: nothing left to protect.
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
         default:                      burst_beats = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_lite_burst_tracker.sv
// ahb_lite_burst_tracker: counts the remaining beats of a fixed-length burst.
// Ports:
//   HCLK, HRESETn : clock, async active-low reset
//   accept        : address phase accepted this edge (bus HREADY)
//   resp_err      : ERROR response on a live data phase
//   htrans/hburst : bus transfer type and burst type
//   burst_end     : beat count is zero after this edge's update
module ahb_lite_burst_tracker
   import ahb_lite_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       accept,
   input  logic       resp_err,
   input  logic [1:0] htrans,
   input  logic [2:0] hburst,
   output logic       burst_end
);

   logic [3:0] beat_cnt, cnt_nxt;
   logic       err_seen;

   // IDLE mid-burst only terminates the burst once an ERROR has been seen;
   // a dropped REQ without an error keeps the remaining beats protected.
   always_comb begin
      cnt_nxt = beat_cnt;
      if (accept) begin
         case (htrans)
            HTRANS_NONSEQ: cnt_nxt = burst_beats(hburst);
            HTRANS_SEQ:    if (beat_cnt != 4'd0) cnt_nxt = beat_cnt - 4'd1;
            HTRANS_IDLE:   if (err_seen || resp_err) cnt_nxt = 4'd0;
            default:       cnt_nxt = beat_cnt;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         beat_cnt <= 4'd0;
         err_seen <= 1'b0;
      end else begin
         beat_cnt <= cnt_nxt;
         if (accept && (htrans == HTRANS_IDLE || htrans == HTRANS_NONSEQ))
            err_seen <= 1'b0;
         else if (resp_err)
            err_seen <= 1'b1;
      end
   end

   assign burst_end = (cnt_nxt == 4'd0);

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// ahb_lite_master_arbiter: shares one AHB-Lite bus between masters M0 and M1.
// Ports:
//   HCLK, HRESETn                   : clock, async active-low reset
//   Mx_REQ, Mx_HADDR..Mx_HWDATA     : master x request, address/control, write data
//   Mx_GRANT                        : master x owns the address phase (registered)
//   Mx_HREADY, Mx_HRESP             : ready/response routed back to master x
//   HADDR..HMASTLOCK, HWDATA        : shared bus toward the decoder
//   HREADY, HRESP, HRDATA           : bus return path
//   M_HRDATA                        : read data broadcast to both masters
// Build option: AHB_ARB_FIXED_PRIO_EN -> M0 always wins contention
//               (default: round-robin on last_winner).
// Grant moves only when the bus is idle, not locked and no burst beats remain.
module ahb_lite_master_arbiter
   import ahb_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              M0_REQ,
   input  logic [ADDR_W-1:0] M0_HADDR,
   input  logic [1:0]        M0_HTRANS,
   input  logic              M0_HWRITE,
   input  logic [2:0]        M0_HSIZE,
   input  logic [2:0]        M0_HBURST,
   input  logic [3:0]        M0_HPROT,
   input  logic              M0_HMASTLOCK,
   input  logic [DATA_W-1:0] M0_HWDATA,
   output logic              M0_GRANT,
   output logic              M0_HREADY,
   output logic              M0_HRESP,
   input  logic              M1_REQ,
   input  logic [ADDR_W-1:0] M1_HADDR,
   input  logic [1:0]        M1_HTRANS,
   input  logic              M1_HWRITE,
   input  logic [2:0]        M1_HSIZE,
   input  logic [2:0]        M1_HBURST,
   input  logic [3:0]        M1_HPROT,
   input  logic              M1_HMASTLOCK,
   input  logic [DATA_W-1:0] M1_HWDATA,
   output logic              M1_GRANT,
   output logic              M1_HREADY,
   output logic              M1_HRESP,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic [DATA_W-1:0] HRDATA,
   output logic [DATA_W-1:0] M_HRDATA
);

   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] haddr;
      logic [1:0]        htrans;
      logic              hwrite;
      logic [2:0]        hsize;
      logic [2:0]        hburst;
      logic [3:0]        hprot;
      logic              hmastlock;
   } mreq_t;

   mreq_t [1:0]             mreq;
   mreq_t                   own;
   logic  [1:0][DATA_W-1:0] mwdata;
   logic  [1:0]             req, mready, mresp;
   logic                    grant, data_owner, data_valid;
   logic                    burst_end, arb_pt, rr_pick;

   assign mreq[0] = {M0_REQ, M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE,
                     M0_HBURST, M0_HPROT, M0_HMASTLOCK};
   assign mreq[1] = {M1_REQ, M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE,
                     M1_HBURST, M1_HPROT, M1_HMASTLOCK};
   assign mwdata  = {M1_HWDATA, M0_HWDATA};
   assign req     = {M1_REQ, M0_REQ};

   // ---- address phase: straight from the granted master ----
   assign own       = mreq[grant];
   assign HADDR     = own.haddr;
   assign HTRANS    = own.req ? own.htrans : 2'(HTRANS_IDLE);
   assign HWRITE    = own.hwrite;
   assign HSIZE     = own.hsize;
   assign HBURST    = own.hburst;
   assign HPROT     = own.hprot;
   assign HMASTLOCK = own.req & own.hmastlock;

   // ---- data phase ----
   assign HWDATA   = mwdata[data_owner];
   assign M_HRDATA = HRDATA;

   ahb_lite_burst_tracker u_burst (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .accept    (HREADY),
      .resp_err  (HRESP & data_valid),
      .htrans    (HTRANS),
      .hburst    (HBURST),
      .burst_end (burst_end)
   );

   // Bus HTRANS is already forced IDLE when the owner's REQ is low, so one
   // compare covers both "not requesting" and "requesting but idle".
   assign arb_pt = HREADY & burst_end & ~HMASTLOCK & (HTRANS == HTRANS_IDLE);

`ifdef AHB_ARB_FIXED_PRIO_EN
   assign rr_pick = 1'b0;
`else
   logic last_winner;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         last_winner <= 1'b1;
      else if (arb_pt && (&req))
         last_winner <= rr_pick;
   end

   assign rr_pick = ~last_winner;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant      <= 1'b0;
         data_owner <= 1'b0;
         data_valid <= 1'b0;
      end else if (HREADY) begin
         data_owner <= grant;
         data_valid <= (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
         if (arb_pt) begin
            if (&req)       grant <= rr_pick;
            else if (req[0]) grant <= 1'b0;
            else if (req[1]) grant <= 1'b1;
            // nobody requesting: park on the current owner
         end
      end
   end

   assign M0_GRANT = ~grant;
   assign M1_GRANT = grant;

   // A requester that owns neither phase is held off; an idle master sees ready.
   for (genvar i = 0; i < 2; i++) begin : g_mst
      assign mready[i] = (grant == 1'(i) || (data_valid && data_owner == 1'(i)))
                         ? HREADY : ~req[i];
      assign mresp[i]  = (data_valid && data_owner == 1'(i))
                         ? HRESP : 1'(HRESP_OKAY);
   end

   assign M0_HREADY = mready[0];
   assign M1_HREADY = mready[1];
   assign M0_HRESP  = mresp[0];
   assign M1_HRESP  = mresp[1];

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// tb_ahb_lite_master_arbiter: directed bench for the two-master AHB-Lite arbiter.
module tb_ahb_lite_master_arbiter;
   import ahb_lite_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              HCLK, HRESETn;
   logic              M0_REQ, M0_HWRITE, M0_HMASTLOCK, M0_GRANT, M0_HREADY, M0_HRESP;
   logic [ADDR_W-1:0] M0_HADDR;
   logic [1:0]        M0_HTRANS;
   logic [2:0]        M0_HSIZE, M0_HBURST;
   logic [3:0]        M0_HPROT;
   logic [DATA_W-1:0] M0_HWDATA;
   logic              M1_REQ, M1_HWRITE, M1_HMASTLOCK, M1_GRANT, M1_HREADY, M1_HRESP;
   logic [ADDR_W-1:0] M1_HADDR;
   logic [1:0]        M1_HTRANS;
   logic [2:0]        M1_HSIZE, M1_HBURST;
   logic [3:0]        M1_HPROT;
   logic [DATA_W-1:0] M1_HWDATA;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]        HSIZE, HBURST;
   logic [3:0]        HPROT;
   logic [DATA_W-1:0] HWDATA, HRDATA, M_HRDATA;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] SEQ8 [10] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ,
                                        HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ,
                                        HTRANS_SEQ, HTRANS_SEQ};

   ahb_lite_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .M0_REQ(M0_REQ), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
      .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
      .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
      .M0_GRANT(M0_GRANT), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
      .M1_REQ(M1_REQ), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
      .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
      .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
      .M1_GRANT(M1_GRANT), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .M_HRDATA(M_HRDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drv(input int m, input logic req, input logic [1:0] tr,
                      input logic [31:0] a, input logic [2:0] b, input logic lk);
      if (m == 0) begin
         M0_REQ = req; M0_HTRANS = tr; M0_HADDR = a; M0_HBURST = b; M0_HMASTLOCK = lk;
      end else begin
         M1_REQ = req; M1_HTRANS = tr; M1_HADDR = a; M1_HBURST = b; M1_HMASTLOCK = lk;
      end
   endtask

   task automatic rst();
      HRESETn = 1'b0;
      drv(0, 1'b0, HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0);
      drv(1, 1'b0, HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0);
      HREADY = 1'b1;
      HRESP  = 1'b0;
      nxt();
      HRESETn = 1'b1;
   endtask

   initial begin
      M0_HWRITE = 1'b1; M0_HSIZE = HSIZE_WORD; M0_HPROT = 4'h3; M0_HWDATA = '0;
      M1_HWRITE = 1'b0; M1_HSIZE = HSIZE_WORD; M1_HPROT = 4'h3; M1_HWDATA = '0;
      HRDATA = 32'hCAFE_F00D;

      // ---- reset state ----
      HRESETn = 1'b0;
      drv(0, 1'b0, HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0);
      drv(1, 1'b0, HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0);
      HREADY = 1'b1; HRESP = 1'b0;
      #2;
      chk("rst_m0_grant", M0_GRANT, 1);
      chk("rst_m1_grant", M1_GRANT, 0);
      chk("rst_htrans",   HTRANS,   HTRANS_IDLE);
      chk("rst_m0_hresp", M0_HRESP, 0);
      chk("rst_m1_hresp", M1_HRESP, 0);
      nxt();
      HRESETn = 1'b1;
      #1;
      chk("idle_m0_hready", M0_HREADY, 1);
      chk("idle_m1_hready", M1_HREADY, 1);
      chk("hrdata_bcast",   M_HRDATA,  32'hCAFE_F00D);

      // ---- M1 alone ----
      rst();
      drv(1, 1'b1, HTRANS_NONSEQ, 32'h100, HBURST_SINGLE, 1'b0);
      #1;
      chk("m1solo_grant0", M1_GRANT,  0);
      chk("m1solo_stall",  M1_HREADY, 0);
      chk("m1solo_idle",   HTRANS,    HTRANS_IDLE);
      nxt();
      chk("m1solo_grant1", M1_GRANT,  1);
      chk("m1solo_m0g",    M0_GRANT,  0);
      chk("m1solo_haddr",  HADDR,     32'h100);
      chk("m1solo_htrans", HTRANS,    HTRANS_NONSEQ);
      chk("m1solo_hready", M1_HREADY, 1);
      nxt();
      drv(1, 1'b0, HTRANS_IDLE, 32'h100, HBURST_SINGLE, 1'b0);
      M0_HWDATA = 32'h2222_2222; M1_HWDATA = 32'h1111_1111; HRESP = 1'b1;
      #1;
      chk("m1solo_hresp1", M1_HRESP, 1);
      chk("m1solo_hresp0", M0_HRESP, 0);
      chk("m1solo_hwdata", HWDATA,   32'h1111_1111);
      nxt();
      chk("m1solo_noresp", M1_HRESP, 0);
      chk("m1solo_park",   M1_GRANT, 1);

      // ---- contention with single transfers ----
      rst();
      for (int k = 0; k < 4; k++) begin
         drv(0, 1'b1, HTRANS_IDLE, 32'h10, HBURST_SINGLE, 1'b0);
         drv(1, 1'b1, HTRANS_IDLE, 32'h20, HBURST_SINGLE, 1'b0);
         nxt();
`ifdef AHB_ARB_FIXED_PRIO_EN
         chk($sformatf("rr_grant%0d", k), M1_GRANT, 0);
`else
         chk($sformatf("rr_grant%0d", k), M1_GRANT, k % 2);
`endif
         drv(0, 1'b1, HTRANS_NONSEQ, 32'h10, HBURST_SINGLE, 1'b0);
         drv(1, 1'b1, HTRANS_NONSEQ, 32'h20, HBURST_SINGLE, 1'b0);
         #1;
`ifdef AHB_ARB_FIXED_PRIO_EN
         chk($sformatf("rr_haddr%0d", k), HADDR, 32'h10);
`else
         chk($sformatf("rr_haddr%0d", k), HADDR, (k % 2) ? 32'h20 : 32'h10);
`endif
         nxt();
      end

      // ---- INCR8 with two BUSY cycles, M1 waiting ----
      rst();
      drv(1, 1'b1, HTRANS_NONSEQ, 32'h700, HBURST_SINGLE, 1'b0);
      begin
         int beat;
         beat = 0;
         for (int i = 0; i < 10; i++) begin
            drv(0, 1'b1, SEQ8[i], 32'h200 + 32'(4 * beat), HBURST_INCR8, 1'b0);
            #1;
            chk($sformatf("incr8_hold%0d", i), M1_GRANT, 0);
            if (i == 3) chk("incr8_haddr", HADDR, 32'h208);
            if (SEQ8[i] != HTRANS_BUSY) beat++;
            nxt();
         end
      end
      drv(0, 1'b0, HTRANS_IDLE, 32'h220, HBURST_SINGLE, 1'b0);
      #1;
      chk("incr8_lastdp", M1_GRANT, 0);
      nxt();
      chk("incr8_handover", M1_GRANT, 1);
      chk("incr8_m1addr",   HADDR,    32'h700);

      // ---- INCR4 with REQ dropped mid-burst: counter keeps the grant ----
      rst();
      drv(1, 1'b1, HTRANS_NONSEQ, 32'h700, HBURST_SINGLE, 1'b0);
      drv(0, 1'b1, HTRANS_NONSEQ, 32'h400, HBURST_INCR4, 1'b0); nxt();
      drv(0, 1'b1, HTRANS_BUSY,   32'h404, HBURST_INCR4, 1'b0); nxt();
      drv(0, 1'b1, HTRANS_SEQ,    32'h404, HBURST_INCR4, 1'b0); nxt();
      drv(0, 1'b1, HTRANS_SEQ,    32'h408, HBURST_INCR4, 1'b0); nxt();
      drv(0, 1'b0, HTRANS_IDLE,   32'h40C, HBURST_INCR4, 1'b0); nxt();
      chk("incr4_drop_hold", M1_GRANT, 0);
      drv(0, 1'b1, HTRANS_SEQ,    32'h40C, HBURST_INCR4, 1'b0);
      #1;
      chk("incr4_resume", HADDR, 32'h40C);
      nxt();
      drv(0, 1'b0, HTRANS_IDLE,   32'h410, HBURST_SINGLE, 1'b0);
      #1;
      chk("incr4_end_hold", M1_GRANT, 0);
      nxt();
      chk("incr4_handover", M1_GRANT, 1);

      // ---- ERROR terminates the burst early ----
      rst();
      drv(1, 1'b1, HTRANS_NONSEQ, 32'h700, HBURST_SINGLE, 1'b0);
      drv(0, 1'b1, HTRANS_NONSEQ, 32'h500, HBURST_INCR4, 1'b0); nxt();
      drv(0, 1'b1, HTRANS_SEQ,    32'h504, HBURST_INCR4, 1'b0); nxt();
      drv(0, 1'b0, HTRANS_IDLE,   32'h508, HBURST_INCR4, 1'b0);
      HREADY = 1'b0; HRESP = 1'b1;
      #1;
      chk("err_m0_hresp",  M0_HRESP,  1);
      chk("err_m1_hresp",  M1_HRESP,  0);
      chk("err_m0_hready", M0_HREADY, 0);
      nxt();
      HREADY = 1'b1;
      #1;
      chk("err_hold", M1_GRANT, 0);
      nxt();
      HRESP = 1'b0;
      #1;
      chk("err_handover", M1_GRANT, 1);

      // ---- locked sequence with an IDLE gap ----
      rst();
      drv(1, 1'b1, HTRANS_NONSEQ, 32'h700, HBURST_SINGLE, 1'b0);
      drv(0, 1'b1, HTRANS_NONSEQ, 32'h600, HBURST_SINGLE, 1'b1); nxt();
      drv(0, 1'b1, HTRANS_NONSEQ, 32'h604, HBURST_SINGLE, 1'b1);
      #1;
      chk("lock_hold1", M1_GRANT, 0);
      nxt();
      drv(0, 1'b1, HTRANS_IDLE,   32'h608, HBURST_SINGLE, 1'b1);
      #1;
      chk("lock_gap_hml", HMASTLOCK, 1);
      chk("lock_hold2",   M1_GRANT,  0);
      nxt();
      drv(0, 1'b1, HTRANS_NONSEQ, 32'h608, HBURST_SINGLE, 1'b1);
      #1;
      chk("lock_gap_held", M1_GRANT, 0);
      nxt();
      drv(0, 1'b0, HTRANS_IDLE,   32'h60C, HBURST_SINGLE, 1'b1);
      #1;
      chk("lock_forced0", HMASTLOCK, 0);
      chk("lock_hold3",   M1_GRANT,  0);
      nxt();
      chk("lock_release", M1_GRANT, 1);

      // ---- wait states on M0's last data phase during handover ----
      rst();
      M0_HWDATA = 32'hAAAA_0000; M1_HWDATA = 32'hBBBB_0000;
      drv(0, 1'b1, HTRANS_NONSEQ, 32'h300, HBURST_SINGLE, 1'b0);
      drv(1, 1'b1, HTRANS_NONSEQ, 32'h400, HBURST_SINGLE, 1'b0);
      #1;
      chk("ws_m1_stall0", M1_HREADY, 0);
      nxt();
      drv(0, 1'b0, HTRANS_IDLE, 32'h300, HBURST_SINGLE, 1'b0);
      HREADY = 1'b0;
      for (int w = 0; w < 2; w++) begin
         #1;
         chk($sformatf("ws_m0_hready%0d", w), M0_HREADY, 0);
         chk($sformatf("ws_hwdata%0d", w),    HWDATA,    32'hAAAA_0000);
         chk($sformatf("ws_m1_grant%0d", w),  M1_GRANT,  0);
         chk($sformatf("ws_m1_stall%0d", w),  M1_HREADY, 0);
         nxt();
      end
      HREADY = 1'b1;
      #1;
      chk("ws_m0_done",   M0_HREADY, 1);
      chk("ws_m1_wait",   M1_HREADY, 0);
      chk("ws_m1_grant2", M1_GRANT,  0);
      nxt();
      chk("ws_m1_granted", M1_GRANT,  1);
      chk("ws_m1_haddr",   HADDR,     32'h400);
      chk("ws_m1_hready",  M1_HREADY, 1);

      // ---- asynchronous reset in the middle of M1's transfer ----
      HRESETn = 1'b0;
      #1;
      chk("arst_m0_grant",  M0_GRANT,  1);
      chk("arst_htrans",    HTRANS,    HTRANS_IDLE);
      chk("arst_m1_hready", M1_HREADY, 0);
      nxt();
      HRESETn = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
